// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : dmem_pkg                                                   |
// | Description : Shared definitions for the data memory controller. Holds   |
// |               funct3 access codes, the controller state encoding, the    |
// |               default memory depth and the load lane/extend helpers.     |
// | Macros      : DMEM_MISALIGN_TRAP_EN (is_misaligned is used only when it  |
// |               is defined)                                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_DEPTH_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR      = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  // Unsupported codes return zero.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = word;
      F3_BU:   r = {24'd0, b};
      F3_HU:   r = {16'd0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Halfword with odd address, or word not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] off);
    return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
           ((f3 == F3_W) && (off != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_bram                                                  |
// | Description : Single-port word memory with per-byte write enables and a  |
// |               registered read (data appears the cycle after the address).|
// |               Contents are never reset.                                  |
// | Ports       : clk      - clock                                           |
// |               addr_i   - word index                                      |
// |               we_i     - byte write enables (bit n -> bits 8n+7:8n)      |
// |               wdata_i  - write data, already placed in its lanes         |
// |               rdata_o  - word read at the previous clock edge            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dmem_bram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : data_mem_ctrl                                              |
// | Description : Load/store controller in front of a byte-enabled data      |
// |               memory. Every access takes a fixed three cycles:           |
// |               IDLE (accept) -> RD_WAIT or WR -> RESP.                    |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               mem_read / mem_write - request strobes (write wins)        |
// |               addr, funct3, wdata  - byte address, size/sign, store data |
// |               stall                - core must hold request stable       |
// |               rdata                - extended load result (held)         |
// |               misalign             - RESP-cycle pulse for bad alignment  |
// | Macros      : DMEM_MISALIGN_TRAP_EN - enables misalign detection/port    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = AW + 2;  // byte offset plus word index

  state_e        state_q, state_d;
  logic [LW-1:0] addr_q;
  logic [2:0]    funct3_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          busy;
  logic          accept;
  logic          mis;

  logic [AW-1:0] bram_addr;
  logic [3:0]    bram_we;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   bram_rdata;

  // Address bits above the memory size wrap around.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:LW];

  assign accept = (state_q == ST_IDLE) && (mem_read || mem_write);

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = mem_read || mem_write;
        if (mem_write)     state_d = ST_WR;
        else if (mem_read) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        busy    = 1'b1;
        state_d = ST_RESP;
      end
      ST_WR: begin
        busy    = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gating keeps stall low while reset is held even if a request is
  // presented on the inputs.
  assign stall = rst_n && busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= addr[LW-1:0];
        funct3_q <= funct3;
        wdata_q  <= wdata;
      end
      if (state_q == ST_RD_WAIT) begin
        rdata_q <= rdata_d;
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= is_misaligned(funct3, addr[1:0]);
    end
  end

  assign mis      = mis_q;
  assign misalign = (state_q == ST_RESP) && mis_q;
`else
  assign mis = 1'b0;
`endif

  // Store lane placement: data is replicated across lanes so only the byte
  // enables decide what lands in memory.
  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = wdata_q;
    case (funct3_q)
      F3_B: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      F3_W:    lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  end

  // The read is issued straight from the request inputs in the accept cycle
  // so the word is ready during RD_WAIT.
  assign bram_addr = (state_q == ST_IDLE) ? addr[LW-1:2] : addr_q[LW-1:2];
  assign bram_we   = ((state_q == ST_WR) && !mis) ? lane_be : 4'b0000;

  assign rdata_d = mis ? 32'd0 : load_extend(funct3_q, addr_q[1:0], bram_rdata);
  assign rdata   = rdata_q;

  dmem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bram (
    .clk     (clk),
    .addr_i  (bram_addr),
    .we_i    (bram_we),
    .wdata_i (lane_wdata),
    .rdata_o (bram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_data_mem_ctrl                                           |
// | Description : Self-checking bench for data_mem_ctrl. A byte-level memory |
// |               image and load-result register form the reference; named   |
// |               scenarios are followed by randomized load/store traffic.   |
// | Macros      : DMEM_MISALIGN_TRAP_EN - also exercises the misalign port   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic        stall;
  logic [31:0] rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .funct3    (funct3),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .misalign  (misalign)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m [DEPTH];   // reference memory image
  logic [31:0] rd_exp;      // reference load-result register

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned idx, b, h;
    logic [31:0] w;
    idx = (a / 4) % DEPTH;
    w   = m[idx];
    b   = (w >> (8 * (a % 4))) & 32'hFF;
    h   = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int unsigned idx, nbytes, off;
    idx    = (a / 4) % DEPTH;
    nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    off    = (f3 == 3'd0) ? a % 4 : (f3 == 3'd1) ? ((a / 2) % 2) * 2 : 0;
    for (int i = 0; i < int'(nbytes); i++) begin
      m[idx][8*(off+i) +: 8] = wd[8*i +: 8];
    end
  endtask

  // One complete access. Entered shortly after a rising edge with the DUT
  // idle; returns at the same phase with the DUT idle again.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] wd);
    bit mis;
    mem_read = rd; mem_write = wr; addr = a; funct3 = f3; wdata = wd;
    #1 check("stall_accept", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    check("stall_busy", {31'd0, stall}, 32'd1);
    mis = ref_mis(f3, a);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misalign_busy", {31'd0, misalign}, 32'd0);
`endif
    if (wr) begin
      if (!mis) ref_store(f3, a, wd);
    end else begin
      rd_exp = mis ? 32'd0 : ref_load(f3, a);
    end
    @(posedge clk); #1;
    check("stall_resp", {31'd0, stall}, 32'd0);
    check("rdata_resp", rdata, rd_exp);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misalign_resp", {31'd0, misalign}, {31'd0, mis});
`endif
    // Anything presented during RESP must be ignored.
    mem_read  = 1'($urandom);
    mem_write = 1'($urandom);
    addr      = $urandom;
    funct3    = 3'($urandom);
    wdata     = $urandom;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    #1 check("stall_idle", {31'd0, stall}, 32'd0);
  endtask

  logic [31:0] prev, saved;

  initial begin
    rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
    addr = '0; funct3 = F3_W; wdata = '0;
    rd_exp = '0;
    #2;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("reset_misalign", {31'd0, misalign}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'(i * 4), F3_W, $urandom);

    // Word store and load.
    access(1'b0, 1'b1, 32'h10, F3_W, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h10, F3_W, 32'h0);
    check("lw_0x10", rdata, 32'hDEADBEEF);

    // Byte store, signed/unsigned byte loads.
    access(1'b0, 1'b1, 32'h13, F3_B, 32'h00000080);
    access(1'b1, 1'b0, 32'h13, F3_B, 32'h0);
    check("lb_0x13", rdata, 32'hFFFFFF80);
    access(1'b1, 1'b0, 32'h13, F3_BU, 32'h0);
    check("lbu_0x13", rdata, 32'h00000080);
    access(1'b1, 1'b0, 32'h10, F3_W, 32'h0);
    check("lw_0x10_after_sb", rdata, 32'h80ADBEEF);

    // Halfword store to the upper half leaves the lower half alone.
    saved = m[8];
    access(1'b0, 1'b1, 32'h22, F3_H, 32'h00008001);
    access(1'b1, 1'b0, 32'h22, F3_H, 32'h0);
    check("lh_0x22", rdata, 32'hFFFF8001);
    access(1'b1, 1'b0, 32'h22, F3_HU, 32'h0);
    check("lhu_0x22", rdata, 32'h00008001);
    access(1'b1, 1'b0, 32'h20, F3_W, 32'h0);
    check("low_half_0x20", {16'd0, rdata[15:0]}, {16'd0, saved[15:0]});

    // Read and write together is a store; rdata keeps the last load.
    prev = rdata;
    access(1'b1, 1'b1, 32'h30, F3_W, 32'h12345678);
    check("both_rdata_held", rdata, prev);
    access(1'b1, 1'b0, 32'h30, F3_W, 32'h0);
    check("lw_0x30", rdata, 32'h12345678);

    // Reset while the store sits in WR: nothing is written.
    saved = m[16];
    mem_write = 1'b1; addr = 32'h40; funct3 = F3_W; wdata = 32'hAAAAAAAA;
    @(posedge clk); #1;
    check("wr_stall", {31'd0, stall}, 32'd1);
    mem_write = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_stall", {31'd0, stall}, 32'd0);
    check("midreset_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_exp = 32'd0;
    check("post_reset_idle", {31'd0, stall}, 32'd0);
    access(1'b1, 1'b0, 32'h40, F3_W, 32'h0);
    check("lw_0x40_prior", rdata, saved);

`ifdef DMEM_MISALIGN_TRAP_EN
    access(1'b1, 1'b0, 32'h41, F3_W, 32'h0);
    check("lw_0x41_rdata", rdata, 32'd0);
    saved = m[16];
    access(1'b0, 1'b1, 32'h41, F3_W, 32'h55555555);
    access(1'b1, 1'b0, 32'h40, F3_W, 32'h0);
    check("sw_0x41_suppressed", rdata, saved);
`endif

    // Randomized traffic, including unsupported codes and high address bits.
    for (int n = 0; n < 400; n++) begin
      int op;
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, $urandom, 3'($urandom_range(0, 7)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
